ldm_stm_sequencer: RTL and testbench
====================================

Name: ldm_stm_sequencer

Overview:
- Multi-register transfer engine for ARM LDM/STM.
- Walks a 16-bit register list lowest-to-highest and generates word memory accesses.
- Drives the banked register file: read ports for STM, write/PC ports for LDM, plus mode override for user-bank (S-bit) transfers.
- Sits between the decode/execute stage and the data-memory interface; execute stalls while busy=1.

Parameters:
- USR_MODE, 5'b10000, mode value driven on rf_mode when user_bank=1

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  launch a transfer; accepted only when busy=0
- is_load  input  1  1=LDM, 0=STM
- pre_index  input  1  P bit: 1=before, 0=after
- up  input  1  U bit: 1=increment, 0=decrement
- writeback  input  1  W bit: update base register
- user_bank  input  1  S bit: access user-mode bank
- base_reg  input  4  base register number
- base_addr  input  32  current base register value
- reg_list  input  16  register list, bit i = Ri
- mode  input  5  current CPSR mode
- busy  output  1  sequencer active
- done  output  1  one-cycle completion pulse
- mem_req  output  1  memory request
- mem_we  output  1  1=write
- mem_addr  output  32  word address
- mem_wdata  output  32  store data
- mem_rdata  input  32  load data, valid with mem_ack
- mem_ack  input  1  access complete
- rf_r_addr  output  4  register file read address
- rf_r_data  input  32  register file read data
- rf_w_addr  output  4  register file write address
- rf_w_data  output  32  register file write data
- rf_write_reg  output  1  register write strobe (r0-r14)
- rf_write_pc  output  1  PC write strobe
- rf_pc_data  output  32  PC write data
- rf_mode  output  5  mode used by the register file for banking

Behaviour:
- Reset: all outputs 0, rf_mode=mode, state=IDLE, latched operands cleared. Reset mid-transfer aborts immediately; no further strobes.
- IDLE: busy=0. start=1 latches all inputs and goes to SETUP; busy=1 from the next cycle. start while busy=1 is ignored.
- SETUP (1 cycle):
  - N = popcount(reg_list).
  - First address: IA=base; IB=base+4; DA=base-4N+4; DB=base-4N.
  - Writeback value: up ? base+4N : base-4N, modulo 2^32.
  - N=0 goes straight to DONE: no memory access, no writeback.
- XFER:
  - Current register = lowest remaining set bit.
  - mem_req=1, mem_we=~is_load, mem_addr=current address.
  - mem_req is held with stable addr/data until mem_ack=1 is sampled.
  - On the ack cycle: clear the bit, address += 4; if the list is now empty go to WB, else stay in XFER. The next request starts the following cycle, so mem_req deasserts for one cycle between beats.
  - STM: rf_r_addr=current register (combinational); mem_wdata=rf_r_data.
  - LDM, r0-r14: rf_write_reg=1, rf_w_addr=reg, rf_w_data=mem_rdata, all in the ack cycle only.
  - LDM, r15: rf_write_pc=1, rf_pc_data=mem_rdata; rf_write_reg stays 0.
  - mem_ack outside XFER is ignored.
- WB (1 cycle): if writeback=1 and not (is_load and base_reg set in the original list), then rf_write_reg=1, rf_w_addr=base_reg, rf_w_data=writeback value. A loaded base therefore wins over writeback.
- DONE: done=1 for 1 cycle, busy=0 from the next cycle, state=IDLE. A new start is accepted in the cycle after done.
- rf_mode: USR_MODE while busy=1 and user_bank=1; otherwise mode.
- Latency with zero-wait memory (ack in the first request cycle): 2N+3 cycles from start to done.

Test Plan:
- STM IA, base=0x1000, list=0x000E, W=1, ack every request:
  - writes to 0x1000/0x1004/0x1008 with rf_r_addr 1, 2, 3.
  - WB writes r[base_reg]=0x100C; done after 9 cycles.
- LDM DB, base=0x2000, list=0x8001, mem_rdata 0xAA then 0xBB:
  - reads 0x1FF8 then 0x1FFC.
  - r0=0xAA via rf_write_reg; PC=0xBB via rf_write_pc only.
- LDM IB, base_reg=4, list=0x0010, W=1: reads 0x1004 (base=0x1000); r4=loaded value; no WB strobe.
- Empty list with W=1: no mem_req, no rf strobes; done 2 cycles after start.
- STM with S=1 in mode 5'b10001 (FIQ), list=0x0100: rf_mode=5'b10000 throughout busy; rf_mode returns to 5'b10001 after done.
- Wait states and reset: hold mem_ack low 3 cycles; mem_req/mem_addr stay stable. Assert rst mid-XFER: all outputs 0 immediately; no strobes follow after rst releases.

Source files
------------

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: ARM LDM/STM multi-register transfer engine.
// Walks reg_list low-to-high, one word access per set bit.
module ldm_stm_sequencer #(
    parameter logic [4:0] USR_MODE = 5'b10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        pre_index,
    input  logic        up,
    input  logic        writeback,
    input  logic        user_bank,
    input  logic [3:0]  base_reg,
    input  logic [31:0] base_addr,
    input  logic [15:0] reg_list,
    input  logic [4:0]  mode,
    output logic        busy,
    output logic        done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [3:0]  rf_r_addr,
    input  logic [31:0] rf_r_data,
    output logic [3:0]  rf_w_addr,
    output logic [31:0] rf_w_data,
    output logic        rf_write_reg,
    output logic        rf_write_pc,
    output logic [31:0] rf_pc_data,
    output logic [4:0]  rf_mode
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_WB,
        S_DONE
    } state_t;

    state_t      state;
    logic        ld_q;
    logic        pre_q;
    logic        up_q;
    logic        wb_q;
    logic        usr_q;
    logic [3:0]  breg_q;
    logic [31:0] base_q;
    logic [31:0] addr_q;
    logic [31:0] wbval_q;
    logic [15:0] list_q;
    logic [15:0] orig_q;
    logic        req_q;

    logic [4:0]  cnt;
    logic [31:0] span;
    logic [3:0]  cur;
    logic        ack_beat;
    logic        ld_beat;
    logic        reg_beat;
    logic        pc_beat;
    logic        wb_wr;
    logic        st_beat;

    // number of registers still in the list (full list during setup)
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(list_q[i]);
        end
    end

    assign span = {25'd0, cnt, 2'b00};

    // lowest remaining register is the one being transferred
    always_comb begin
        cur = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (list_q[i]) begin
                cur = 4'(i);
            end
        end
    end

    // sequencing state, latched operands and running address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            ld_q    <= 1'b0;
            pre_q   <= 1'b0;
            up_q    <= 1'b0;
            wb_q    <= 1'b0;
            usr_q   <= 1'b0;
            breg_q  <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            wbval_q <= '0;
            list_q  <= '0;
            orig_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        ld_q   <= is_load;
                        pre_q  <= pre_index;
                        up_q   <= up;
                        wb_q   <= writeback;
                        usr_q  <= user_bank;
                        breg_q <= base_reg;
                        base_q <= base_addr;
                        list_q <= reg_list;
                        orig_q <= reg_list;
                        state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    wbval_q <= up_q ? base_q + span : base_q - span;
                    unique case ({up_q, pre_q})
                        2'b10:   addr_q <= base_q;
                        2'b11:   addr_q <= base_q + 32'd4;
                        2'b00:   addr_q <= base_q - span + 32'd4;
                        default: addr_q <= base_q - span;
                    endcase
                    if (cnt == 5'd0) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_XFER;
                        req_q <= 1'b1;
                    end
                end
                S_XFER: begin
                    if (req_q) begin
                        if (mem_ack) begin
                            req_q       <= 1'b0;
                            list_q[cur] <= 1'b0;
                            addr_q      <= addr_q + 32'd4;
                        end
                    end else if (list_q == 16'd0) begin
                        state <= S_WB;
                    end else begin
                        req_q <= 1'b1;
                    end
                end
                S_WB: begin
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // a loaded base register takes priority over writeback
    assign ack_beat = (state == S_XFER) && req_q && mem_ack;
    assign ld_beat  = ack_beat && ld_q;
    assign reg_beat = ld_beat && (cur != 4'd15);
    assign pc_beat  = ld_beat && (cur == 4'd15);
    assign st_beat  = req_q && !ld_q;
    assign wb_wr    = (state == S_WB) && wb_q && !(ld_q && orig_q[breg_q]);

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign mem_req   = req_q;
    assign mem_we    = st_beat;
    assign mem_addr  = req_q ? addr_q : 32'd0;
    assign rf_r_addr = st_beat ? cur : 4'd0;
    assign mem_wdata = st_beat ? rf_r_data : 32'd0;

    assign rf_write_reg = reg_beat || wb_wr;
    assign rf_w_addr    = reg_beat ? cur :
                          wb_wr ? breg_q : 4'd0;
    assign rf_w_data    = reg_beat ? mem_rdata :
                          wb_wr ? wbval_q : 32'd0;
    assign rf_write_pc  = pc_beat;
    assign rf_pc_data   = pc_beat ? mem_rdata : 32'd0;

    assign rf_mode = (busy && usr_q) ? USR_MODE : mode;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb_ldm_stm_sequencer: directed and random LDM/STM transfers
// compared against a timeline model built from the transfer rules.
module tb_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_load;
    logic        pre_index;
    logic        up;
    logic        writeback;
    logic        user_bank;
    logic [3:0]  base_reg;
    logic [31:0] base_addr;
    logic [15:0] reg_list;
    logic [4:0]  mode;
    logic        busy;
    logic        done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [3:0]  rf_r_addr;
    logic [31:0] rf_r_data;
    logic [3:0]  rf_w_addr;
    logic [31:0] rf_w_data;
    logic        rf_write_reg;
    logic        rf_write_pc;
    logic [31:0] rf_pc_data;
    logic [4:0]  rf_mode;

    logic [31:0] rfmem [16];
    logic [4:0]  prev_md;
    int          vectors = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign rf_r_data = rfmem[rf_r_addr];

    ldm_stm_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .is_load      (is_load),
        .pre_index    (pre_index),
        .up           (up),
        .writeback    (writeback),
        .user_bank    (user_bank),
        .base_reg     (base_reg),
        .base_addr    (base_addr),
        .reg_list     (reg_list),
        .mode         (mode),
        .busy         (busy),
        .done         (done),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .rf_r_addr    (rf_r_addr),
        .rf_r_data    (rf_r_data),
        .rf_w_addr    (rf_w_addr),
        .rf_w_data    (rf_w_data),
        .rf_write_reg (rf_write_reg),
        .rf_write_pc  (rf_write_pc),
        .rf_pc_data   (rf_pc_data),
        .rf_mode      (rf_mode)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        is_load   = 1'($urandom);
        pre_index = 1'($urandom);
        up        = 1'($urandom);
        writeback = 1'($urandom);
        user_bank = 1'($urandom);
        base_reg  = 4'($urandom);
        base_addr = $urandom;
        reg_list  = 16'($urandom);
    endtask

    // fw >= 0 fixes the wait states per beat, fw < 0 randomizes them
    task automatic run_txn(input logic ld, input logic pp, input logic uu,
                           input logic ww, input logic ss,
                           input logic [3:0] br, input logic [31:0] base,
                           input logic [15:0] lst, input logic [4:0] md,
                           input int fw);
        int          n;
        int          rg [16];
        int          st [16];
        int          wt [16];
        int          dn;
        int          wbc;
        int          act;
        bit          ackc;
        bit          outside;
        bit          wreg_e;
        bit          wpc_e;
        logic [31:0] first;
        logic [31:0] wbv;
        logic [31:0] rd;

        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (lst[i]) begin
                rg[n] = i;
                n++;
            end
        end
        if (uu) begin
            first = pp ? base + 32'd4 : base;
            wbv   = base + 32'(4 * n);
        end else begin
            first = pp ? base - 32'(4 * n) : base - 32'(4 * n) + 32'd4;
            wbv   = base - 32'(4 * n);
        end
        for (int k = 0; k < n; k++) begin
            wt[k] = (fw >= 0) ? fw : int'($urandom_range(0, 3));
            st[k] = (k == 0) ? 2 : st[k-1] + wt[k-1] + 2;
        end
        if (n == 0) begin
            wbc = -1;
            dn  = 2;
        end else begin
            wbc = st[n-1] + wt[n-1] + 2;
            dn  = wbc + 1;
        end

        @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        chk("idle_mode", rf_mode, prev_md);
        is_load   = ld;
        pre_index = pp;
        up        = uu;
        writeback = ww;
        user_bank = ss;
        base_reg  = br;
        base_addr = base;
        reg_list  = lst;
        mode      = md;
        mem_ack   = 1'b0;
        start     = 1'b1;

        for (int c = 1; c <= dn; c++) begin
            @(negedge clk);
            act = -1;
            for (int k = 0; k < n; k++) begin
                if (c >= st[k] && c <= st[k] + wt[k]) act = k;
            end
            ackc    = (act >= 0) && (c == st[act] + wt[act]);
            outside = (c < 2) || (n == 0) || (c >= wbc);
            rd        = $urandom;
            mem_rdata = rd;
            if (act >= 0) mem_ack = ackc;
            else if (outside) mem_ack = 1'($urandom);
            else mem_ack = 1'b0;
            start = 1'($urandom);
            scramble();
            #1;
            wreg_e = (ackc && ld && rg[act] != 15) ||
                     (c == wbc && ww && !(ld && lst[br]));
            wpc_e  = ackc && ld && rg[act] == 15;
            chk("busy", busy, 1'b1);
            chk("done", done, c == dn);
            chk("mem_req", mem_req, act >= 0);
            chk("rf_mode", rf_mode, ss ? 5'b10000 : md);
            chk("wr_reg", rf_write_reg, wreg_e);
            chk("wr_pc", rf_write_pc, wpc_e);
            if (act >= 0) begin
                chk("mem_addr", mem_addr, first + 32'(4 * act));
                chk("mem_we", mem_we, !ld);
                if (!ld) begin
                    chk("r_addr", rf_r_addr, rg[act]);
                    chk("wdata", mem_wdata, rfmem[rg[act]]);
                end
            end
            if (wreg_e) begin
                chk("w_addr", rf_w_addr, ackc ? 4'(rg[act]) : br);
                chk("w_data", rf_w_data, ackc ? rd : wbv);
            end
            if (wpc_e) chk("pc_data", rf_pc_data, rd);
        end
        start   = 1'b0;
        mem_ack = 1'b0;
        prev_md = md;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rfmem[i] = $urandom;
        rst       = 1'b1;
        start     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        mode      = 5'b10011;
        prev_md   = 5'b10011;
        scramble();
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_wreg", rf_write_reg, 1'b0);
        chk("rst_wpc", rf_write_pc, 1'b0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_mode", rf_mode, 5'b10011);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_txn(0, 0, 1, 1, 0, 4'd13, 32'h1000, 16'h000E, 5'b10011, 0);
        run_txn(1, 1, 0, 0, 0, 4'd13, 32'h2000, 16'h8001, 5'b10011, 0);
        run_txn(1, 1, 1, 1, 0, 4'd4, 32'h1000, 16'h0010, 5'b10011, 0);
        run_txn(0, 0, 1, 1, 0, 4'd2, 32'h5000, 16'h0000, 5'b10011, 0);
        run_txn(0, 0, 1, 0, 1, 4'd0, 32'h8000, 16'h0100, 5'b10001, -1);
        run_txn(1, 0, 1, 0, 0, 4'd1, 32'h0600, 16'h00C3, 5'b10001, 3);
        run_txn(0, 1, 0, 1, 0, 4'd3, 32'h0000_0004, 16'hFFFF, 5'b10011, 0);

        @(negedge clk);
        chk("idle_mode", rf_mode, prev_md);
        is_load   = 1'b0;
        pre_index = 1'b0;
        up        = 1'b1;
        writeback = 1'b1;
        user_bank = 1'b1;
        base_reg  = 4'd5;
        base_addr = 32'h3000;
        reg_list  = 16'h00F0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_req", mem_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_req", mem_req, 1'b0);
        chk("arst_we", mem_we, 1'b0);
        chk("arst_addr", mem_addr, 32'd0);
        chk("arst_wdata", mem_wdata, 32'd0);
        chk("arst_raddr", rf_r_addr, 4'd0);
        chk("arst_wreg", rf_write_reg, 1'b0);
        chk("arst_waddr", rf_w_addr, 4'd0);
        chk("arst_wdat", rf_w_data, 32'd0);
        chk("arst_wpc", rf_write_pc, 1'b0);
        chk("arst_pc", rf_pc_data, 32'd0);
        chk("arst_mode", rf_mode, mode);
        @(negedge clk);
        rst     = 1'b0;
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_req", mem_req, 1'b0);
            chk("post_rst_busy", busy, 1'b0);
            chk("post_rst_wreg", rf_write_reg, 1'b0);
            chk("post_rst_wpc", rf_write_pc, 1'b0);
        end
        mem_ack = 1'b0;
        prev_md = mode;

        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 4'($urandom), $urandom,
                    ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom),
                    5'($urandom), -1);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
